popcount_window_accumulator: RTL and testbench
==============================================

// Module: popcount_window_accumulator
// PURPOSE
//  Downstream consumer of the bit population counter output stream (count + valid).
//  Sums the counts over a window of WINDOW valid samples and reports the window sum,
//  the largest single count and a threshold flag. Flush closes a partial window early.
//  Sits directly after the popcount pipeline; no backpressure (popcounter has no ready).
// PARAMETERS
//  CNT_WIDTH  7    width of incoming count (= $clog2(63)+1 for 63-bit popcount)
//  WINDOW     16   valid samples per window; power of two, >= 2
//  THRESHOLD  512  over_thr_o set when window sum > THRESHOLD
//  (derived) SUM_W = CNT_WIDTH + $clog2(WINDOW); WCNT_W = $clog2(WINDOW) + 1
// PORTS
//  clk_i        in   1          clock; all logic on posedge
//  arst_n_i     in   1          asynchronous active-low reset
//  data_i       in   CNT_WIDTH  popcount value; sampled only when data_val_i=1
//  data_val_i   in   1          data_i valid
//  flush_i      in   1          close current window early (single-cycle pulse)
//  sum_o        out  SUM_W      sum of counts in the last closed window
//  max_o        out  CNT_WIDTH  largest single count in the last closed window
//  words_o      out  WCNT_W     number of samples in the last closed window (1..WINDOW)
//  over_thr_o   out  1          sum_o > THRESHOLD for the last closed window
//  sum_val_o    out  1          one-cycle pulse: outputs above updated this cycle
// BEHAVIOUR
//  Reset (arst_n_i=0, async): all outputs 0; accumulator, running max, sample counter 0;
//   state EMPTY. Reset mid-window discards the partial window; no output pulse.
//  States: EMPTY (0 samples held), ACCUM (1..WINDOW-1 samples held).
//   EMPTY : val -> ACCUM (acc=data_i, max=data_i, cnt=1). flush alone -> ignored, stay.
//   ACCUM : val -> acc+=data_i, max=max(max,data_i), cnt+=1.
//           If this makes cnt==WINDOW, or flush_i=1 in same cycle -> close window.
//           flush alone (no val) -> close window with samples held so far.
//  Close window (on clock edge E): sum_o/max_o/words_o/over_thr_o load the final values
//   (including the sample accepted at E, if any); sum_val_o=1 for the cycle after E;
//   acc, max, cnt cleared; state -> EMPTY.
//  WINDOW=... EMPTY+val+flush in same cycle: window of 1 sample closes (words_o=1).
//  Latency: sum_val_o rises 1 cycle after the edge accepting the closing sample/flush.
//  Back-to-back: a sample on the cycle immediately after a close starts the next window;
//   no dead cycle; consecutive windows give sum_val_o pulses WINDOW cycles apart at
//   full rate.
//  Outputs hold between pulses; sum_val_o low otherwise.
//  Arithmetic: unsigned; acc is SUM_W bits, cannot overflow
//   (max WINDOW*(2^CNT_WIDTH-1) < 2^SUM_W). Compare is unsigned, strict >.
//  data_i ignored when data_val_i=0 (X tolerated). flush_i while sum_val_o high is
//   legal and treated normally.
// TESTING
//  1 reset: assert arst_n_i asynchronously mid-cycle -> all outputs 0 immediately,
//    no sum_val_o.
//  2 full window: 16 valid samples of 40 -> 1 cycle after 16th, sum_val_o=1, sum_o=640,
//    max_o=40, words_o=16, over_thr_o=1.
//  3 flush: samples 3,9,5 then flush_i alone -> sum_o=17, max_o=9, words_o=3,
//    over_thr_o=0.
//  4 flush with valid: sample 7 with flush_i in EMPTY -> sum_o=7, words_o=1;
//    flush_i in EMPTY alone -> no pulse.
//  5 gaps + back-to-back: 32 samples of 63 with random val gaps, then full-rate ->
//    two pulses each sum_o=1008, max_o=63; no sample lost.
//  6 reset mid-window: 10 samples, reset, then 16 samples of 1 -> single pulse,
//    sum_o=16, words_o=16.

Source files
------------

// File: rtl/popcount_window_accumulator.sv
// Window accumulator for the popcount stream: sums counts over WINDOW samples,
// tracks the largest count and flags sums above THRESHOLD.
module popcount_window_accumulator #(
    parameter  int CNT_WIDTH = 7,
    parameter  int WINDOW    = 16,
    parameter  int THRESHOLD = 512,
    localparam int SUM_W     = CNT_WIDTH + $clog2(WINDOW),
    localparam int WCNT_W    = $clog2(WINDOW) + 1
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic [CNT_WIDTH-1:0] data_i,
    input  logic                 data_val_i,
    input  logic                 flush_i,
    output logic [SUM_W-1:0]     sum_o,
    output logic [CNT_WIDTH-1:0] max_o,
    output logic [WCNT_W-1:0]    words_o,
    output logic                 over_thr_o,
    output logic                 sum_val_o
);

    typedef enum logic {EMPTY, ACCUM} state_t;

    localparam logic [WCNT_W-1:0] WIN_CNT = WCNT_W'(WINDOW);
    localparam logic [31:0]       THR     = THRESHOLD;

    state_t               state_q;
    logic [SUM_W-1:0]     acc_q;
    logic [CNT_WIDTH-1:0] max_q;
    logic [WCNT_W-1:0]    cnt_q;

    logic [SUM_W-1:0]     base_acc, nxt_acc;
    logic [CNT_WIDTH-1:0] base_max, nxt_max;
    logic [WCNT_W-1:0]    base_cnt, nxt_cnt;
    logic                 close;
    logic                 nxt_over;

    always_comb begin
        base_acc = (state_q == ACCUM) ? acc_q : '0;
        base_max = (state_q == ACCUM) ? max_q : '0;
        base_cnt = (state_q == ACCUM) ? cnt_q : '0;
        nxt_acc  = base_acc;
        nxt_max  = base_max;
        nxt_cnt  = base_cnt;
        if (data_val_i) begin
            nxt_acc = base_acc + SUM_W'(data_i);
            nxt_max = (data_i > base_max) ? data_i : base_max;
            nxt_cnt = base_cnt + WCNT_W'(1);
        end
        // A flush with nothing held (and no sample this cycle) is a no-op.
        close    = (nxt_cnt != '0) && (flush_i || (nxt_cnt == WIN_CNT));
        nxt_over = 32'(nxt_acc) > THR;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= EMPTY;
            acc_q      <= '0;
            max_q      <= '0;
            cnt_q      <= '0;
            sum_o      <= '0;
            max_o      <= '0;
            words_o    <= '0;
            over_thr_o <= 1'b0;
            sum_val_o  <= 1'b0;
        end else begin
            sum_val_o <= close;
            if (close) begin
                sum_o      <= nxt_acc;
                max_o      <= nxt_max;
                words_o    <= nxt_cnt;
                over_thr_o <= nxt_over;
                acc_q      <= '0;
                max_q      <= '0;
                cnt_q      <= '0;
                state_q    <= EMPTY;
            end else begin
                acc_q   <= nxt_acc;
                max_q   <= nxt_max;
                cnt_q   <= nxt_cnt;
                state_q <= (nxt_cnt != '0) ? ACCUM : EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_popcount_window_accumulator.sv
// Directed bench for popcount_window_accumulator: full windows, flush,
// gaps, back-to-back windows, threshold boundary and async reset.
module tb_popcount_window_accumulator;

    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic [6:0]  data_i;
    logic        data_val_i;
    logic        flush_i;
    logic [10:0] sum_o;
    logic [6:0]  max_o;
    logic [4:0]  words_o;
    logic        over_thr_o;
    logic        sum_val_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pulses = 0;
    int pulse_sum_total = 0;
    int last_pulse_cyc = 0;
    int prev_pulse_cyc = 0;
    int p0, t0;

    popcount_window_accumulator dut (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .data_i     (data_i),
        .data_val_i (data_val_i),
        .flush_i    (flush_i),
        .sum_o      (sum_o),
        .max_o      (max_o),
        .words_o    (words_o),
        .over_thr_o (over_thr_o),
        .sum_val_o  (sum_val_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (sum_val_o) begin
            pulses          = pulses + 1;
            pulse_sum_total = pulse_sum_total + int'(sum_o);
            prev_pulse_cyc  = last_pulse_cyc;
            last_pulse_cyc  = cyc;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Junk data while invalid must be ignored by the DUT.
    task automatic step(input logic v, input logic [6:0] d, input logic f);
        data_val_i = v;
        data_i     = v ? d : 7'h7f;
        flush_i    = f;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_out(input string tag, input int s, input int m,
                             input int w, input int o);
        check({tag, ".val"},  int'(sum_val_o),  1);
        check({tag, ".sum"},  int'(sum_o),      s);
        check({tag, ".max"},  int'(max_o),      m);
        check({tag, ".words"}, int'(words_o),   w);
        check({tag, ".over"}, int'(over_thr_o), o);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".val"},  int'(sum_val_o),  0);
        check({tag, ".sum"},  int'(sum_o),      0);
        check({tag, ".max"},  int'(max_o),      0);
        check({tag, ".words"}, int'(words_o),   0);
        check({tag, ".over"}, int'(over_thr_o), 0);
    endtask

    task automatic async_reset(input string tag);
        data_val_i = 1'b0;
        flush_i    = 1'b0;
        #1 arst_n_i = 1'b0;
        #1 check_zero(tag);
        #1 arst_n_i = 1'b1;
    endtask

    initial begin
        arst_n_i   = 1'b0;
        data_i     = '0;
        data_val_i = 1'b0;
        flush_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_zero("por");
        arst_n_i = 1'b1;
        step(0, 0, 0);

        // Full window of 16 x 40
        for (int i = 0; i < 16; i++) step(1, 7'd40, 0);
        check_out("full40", 640, 40, 16, 1);
        step(0, 0, 0);
        check("full40.pulse_one_cycle", int'(sum_val_o), 0);
        check("full40.hold", int'(sum_o), 640);

        // Asynchronous reset mid-cycle with outputs populated
        async_reset("rst_mid");
        step(0, 0, 0);

        // Flush alone closes a partial window
        step(1, 7'd3, 0);
        step(1, 7'd9, 0);
        step(1, 7'd5, 0);
        check("flush.no_early", int'(sum_val_o), 0);
        step(0, 0, 1);
        check_out("flush", 17, 9, 3, 0);

        // Sample with flush in EMPTY, then flush alone in EMPTY
        step(1, 7'd7, 1);
        check_out("flush1", 7, 7, 1, 0);
        step(0, 0, 1);
        check("flush_empty.no_pulse", int'(sum_val_o), 0);
        check("flush_empty.hold", int'(sum_o), 7);

        // Sum exactly at threshold is not over
        for (int i = 0; i < 16; i++) step(1, 7'd32, 0);
        check_out("thr_eq", 512, 32, 16, 0);

        // Largest possible counts, no overflow
        for (int i = 0; i < 16; i++) step(1, 7'd127, 0);
        check_out("maxval", 2032, 127, 16, 1);
        step(0, 0, 0);

        // Gapped window, then back-to-back full-rate window
        p0 = pulses;
        t0 = pulse_sum_total;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 2)) step(0, 0, 0);
            step(1, 7'd63, 0);
        end
        check_out("gap", 1008, 63, 16, 1);
        for (int i = 0; i < 16; i++) step(1, 7'd63, 0);
        check_out("b2b", 1008, 63, 16, 1);
        step(0, 0, 0);
        check("b2b.pulses", pulses - p0, 2);
        check("b2b.total", pulse_sum_total - t0, 2016);
        check("b2b.spacing", last_pulse_cyc - prev_pulse_cyc, 16);

        // Reset discards a partial window
        for (int i = 0; i < 10; i++) step(1, 7'd5, 0);
        async_reset("rst_win");
        p0 = pulses;
        for (int i = 0; i < 16; i++) step(1, 7'd1, 0);
        check_out("after_rst", 16, 1, 16, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("after_rst.pulses", pulses - p0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
